// File: rtl/floo_dst_order_guard_pkg.sv
// Shared constants and helpers for the destination order guard.
// Endpoint ID type is supplied by the chimney, not defined here.
package floo_dst_order_guard_pkg;

  localparam int unsigned DefAxiIdWidth = 4;
  localparam int unsigned DefMaxTxns    = 8;

  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

endpackage

// File: rtl/floo_ord_cnt.sv
// Per-AXI-ID outstanding counter with last destination tracking.
// Raises ok_o when a request to dst_i may be admitted.
module floo_ord_cnt
  import floo_dst_order_guard_pkg::*;
#(
  parameter int unsigned MaxTxns = DefMaxTxns,
  parameter type         id_t    = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  input  id_t  dst_i,
  output logic ok_o
);

  localparam int unsigned     CntW   = cnt_width(MaxTxns);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  id_t             last_q;

  // Simultaneous inc and dec cancel out; both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      (inc_i & ~dec_i & (cnt_q != CntMax)): cnt_d = cnt_q + CntW'(1);
      (dec_i & ~inc_i & (cnt_q != '0)):     cnt_d = cnt_q - CntW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (inc_i) last_q <= dst_i;
    end
  end

  assign ok_o = (cnt_q == '0) |
                ((cnt_q < CntMax) & (last_q == dst_i));

  a_no_underflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (dec_i & ~inc_i) |-> (cnt_q != '0)
  ) else $warning("floo_ord_cnt: response on idle AXI ID ignored");

  a_no_overflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (inc_i & ~dec_i) |-> (cnt_q != CntMax)
  ) else $error("floo_ord_cnt: outstanding count overflow");

endmodule

// File: rtl/floo_dst_order_guard.sv
// Holds back requests whose AXI ID is still in flight to another
// destination, so same-ID responses cannot overtake each other.
module floo_dst_order_guard
  import floo_dst_order_guard_pkg::*;
#(
  parameter int unsigned AxiIdWidth   = DefAxiIdWidth,
  parameter int unsigned MaxTxnsPerId = DefMaxTxns,
  parameter type         id_t         = logic
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AxiIdWidth-1:0] req_axi_id_i,
  input  id_t                   req_dst_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [AxiIdWidth-1:0] req_axi_id_o,
  output id_t                   req_dst_o,
  input  logic                  rsp_done_i,
  input  logic [AxiIdWidth-1:0] rsp_axi_id_i,
  output logic                  stall_o
);

  localparam int unsigned NumIds = 2 ** AxiIdWidth;

  logic [NumIds-1:0] ok_vec;
  logic              ok;
  logic              accept;

  for (genvar i = 0; i < NumIds; i++) begin : g_id
    floo_ord_cnt #(
      .MaxTxns (MaxTxnsPerId),
      .id_t    (id_t)
    ) i_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (accept & (req_axi_id_i == AxiIdWidth'(i))),
      .dec_i  (rsp_done_i & (rsp_axi_id_i == AxiIdWidth'(i))),
      .dst_i  (req_dst_i),
      .ok_o   (ok_vec[i])
    );
  end

  assign ok          = ok_vec[req_axi_id_i];
  assign req_ready_o = ok & (~req_valid_o | req_ready_i);
  assign accept      = req_valid_i & req_ready_o;
  assign stall_o     = req_valid_i & ~ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_o  <= 1'b0;
      req_axi_id_o <= '0;
      req_dst_o    <= '0;
    end else if (accept) begin
      req_valid_o  <= 1'b1;
      req_axi_id_o <= req_axi_id_i;
      req_dst_o    <= req_dst_i;
    end else if (req_ready_i) begin
      req_valid_o  <= 1'b0;
    end
  end

  a_out_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (req_valid_o & ~req_ready_i) |=>
      (req_valid_o & $stable(req_axi_id_o) & $stable(req_dst_o))
  ) else $error("floo_dst_order_guard: output changed while stalled");

endmodule

// File: tb/tb_floo_dst_order_guard.sv
// Table-driven and randomized checks of floo_dst_order_guard
// against a per-ID queue model of outstanding destinations.
module tb_floo_dst_order_guard;

  localparam int MAXT = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [3:0] req_axi_id_i = '0;
  logic [7:0] req_dst_i = '0;
  logic       req_valid_o;
  logic       req_ready_i = 1'b0;
  logic [3:0] req_axi_id_o;
  logic [7:0] req_dst_o;
  logic       rsp_done_i = 1'b0;
  logic [3:0] rsp_axi_id_i = '0;
  logic       stall_o;

  floo_dst_order_guard #(
    .AxiIdWidth   (4),
    .MaxTxnsPerId (MAXT),
    .id_t         (logic [7:0])
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_axi_id_i (req_axi_id_i),
    .req_dst_i    (req_dst_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_axi_id_o (req_axi_id_o),
    .req_dst_o    (req_dst_o),
    .rsp_done_i   (rsp_done_i),
    .rsp_axi_id_i (rsp_axi_id_i),
    .stall_o      (stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit v; int id; int dst; bit rdy; bit rsp; int rid;
    bit e_rdy; bit e_stall; bit e_val; int e_id; int e_dst;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Model: queue of destinations still outstanding per AXI ID.
  int q[16][$];
  bit mv;
  int mid, mdst;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, int id, int dst, bit rdy,
                              bit rsp, int rid, bit er, bit es,
                              bit ev, int ei, int ed);
    vec_t t;
    t = '{v, id, dst, rdy, rsp, rid, er, es, ev, ei, ed};
    return t;
  endfunction

  function automatic bit model_ok(int id, int dst);
    int n;
    n = q[id].size();
    if (n == 0) return 1'b1;
    return (n < MAXT) && (q[id][n-1] == dst);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) q[i].delete();
    mv = 1'b0; mid = 0; mdst = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_ready_i = 1'b0; rsp_done_i = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", req_valid_o, 0);
    chk("rst_id", req_axi_id_o, 0);
    chk("rst_dst", req_dst_o, 0);
    chk("rst_stall", stall_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic apply(input vec_t t, input bit use_model, input string tag);
    bit m_ok, m_rdy, m_stall, acc;
    @(negedge clk_i);
    req_valid_i  = t.v;
    req_axi_id_i = t.id[3:0];
    req_dst_i    = t.dst[7:0];
    req_ready_i  = t.rdy;
    rsp_done_i   = t.rsp;
    rsp_axi_id_i = t.rid[3:0];
    m_ok    = model_ok(t.id, t.dst);
    m_rdy   = m_ok & (!mv | t.rdy);
    m_stall = t.v & !m_ok;
    if (use_model) begin
      t.e_rdy = m_rdy;
      t.e_stall = m_stall;
    end
    #1;
    chk({tag, "_ready"}, req_ready_o, t.e_rdy);
    chk({tag, "_stall"}, stall_o, t.e_stall);
    @(posedge clk_i);
    acc = t.v & m_rdy;
    if (acc) begin
      mv = 1'b1; mid = t.id; mdst = t.dst;
      q[t.id].push_back(t.dst);
    end else if (t.rdy) begin
      mv = 1'b0;
    end
    if (t.rsp && q[t.rid].size() > 0) void'(q[t.rid].pop_front());
    if (use_model) begin
      t.e_val = mv; t.e_id = mid; t.e_dst = mdst;
    end
    #1;
    chk({tag, "_valid"}, req_valid_o, t.e_val);
    if (t.e_val) begin
      chk({tag, "_id"}, req_axi_id_o, t.e_id);
      chk({tag, "_dst"}, req_dst_o, t.e_dst);
    end
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) apply(tbl[i], 1'b0, tag);
    tbl.delete();
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Single request, burst, different-dst stall, release, other ID.
    tbl.push_back(mk(0,0,0,1, 0,0, 1,0, 0,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,3,5,1, 0,0, 1,0, 1,3,5));
    tbl.push_back(mk(0,0,0,1, 0,0, 1,0, 0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,3, 1,0, 0,0,0));
    tbl.push_back(mk(1,3,7,1, 0,0, 0,1, 0,0,0));
    tbl.push_back(mk(1,3,7,1, 1,3, 0,1, 0,0,0));
    tbl.push_back(mk(1,3,7,1, 1,3, 0,1, 0,0,0));
    tbl.push_back(mk(1,3,7,1, 0,0, 1,0, 1,3,7));
    tbl.push_back(mk(1,4,9,1, 0,0, 1,0, 1,4,9));
    tbl.push_back(mk(0,0,0,1, 0,0, 1,0, 0,0,0));
    run_tbl("basic");

    // Saturation at MaxTxnsPerId and release by a response.
    do_reset();
    for (int i = 0; i < MAXT; i++)
      tbl.push_back(mk(1,1,2,1, 0,0, 1,0, 1,1,2));
    tbl.push_back(mk(1,1,2,1, 0,0, 0,1, 0,0,0));
    tbl.push_back(mk(1,1,2,1, 1,1, 0,1, 0,0,0));
    tbl.push_back(mk(1,1,2,1, 0,0, 1,0, 1,1,2));
    tbl.push_back(mk(1,1,2,1, 0,0, 0,1, 0,0,0));
    run_tbl("sat");

    // Output hold under backpressure, then drain.
    do_reset();
    tbl.push_back(mk(1,2,3,0, 0,0, 1,0, 1,2,3));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,5,6,0, 0,0, 0,0, 1,2,3));
    tbl.push_back(mk(0,0,0,1, 0,0, 1,0, 0,0,0));
    tbl.push_back(mk(1,2,3,0, 0,0, 1,0, 1,2,3));
    run_tbl("hold");

    // Asynchronous reset while the output is valid.
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("midrst_valid", req_valid_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tbl.push_back(mk(1,2,9,1, 0,0, 1,0, 1,2,9));
    tbl.push_back(mk(0,0,0,1, 0,0, 1,0, 0,0,0));
    run_tbl("postrst");

    // Response on an idle ID must leave its count at zero.
    do_reset();
    tbl.push_back(mk(0,0,0,1, 1,6, 1,0, 0,0,0));
    tbl.push_back(mk(1,6,1,1, 0,0, 1,0, 1,6,1));
    tbl.push_back(mk(1,6,4,1, 1,6, 0,1, 0,0,0));
    tbl.push_back(mk(1,6,4,1, 0,0, 1,0, 1,6,4));
    run_tbl("uflow");

    // Randomized traffic over a few IDs and destinations.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      vec_t t;
      int rid;
      t = mk(0,0,0,0, 0,0, 0,0, 0,0,0);
      t.v   = ($urandom_range(0, 3) != 0);
      t.id  = $urandom_range(0, 3);
      t.dst = $urandom_range(0, 2);
      t.rdy = ($urandom_range(0, 3) != 0);
      rid   = $urandom_range(0, 3);
      if (q[rid].size() > 0 && $urandom_range(0, 9) < 4) begin
        t.rsp = 1'b1;
        t.rid = rid;
      end
      apply(t, 1'b1, "rand");
    end

    @(negedge clk_i);
    req_valid_i = 1'b0; rsp_done_i = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
